alu_execute_unit: RTL and testbench
===================================

ALU_EXECUTE_UNIT -- requirements
Module: alu_execute_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-006 SHALL have port alu_control  input  3  op code: 000 add, 001 sub, 010 or, 011 and, 101 slt, 100 sll, 110 srl, 111 sra.
REQ-007 SHALL have ports src_a, src_b  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-009 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have port zero  output  1  registered (result == 0).
REQ-012 SHALL have port illegal  output  1  registered flag: op not supported in this build.

Function
REQ-013 FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on accepted shift op with src_b[4:0] != 0; SHIFT->IDLE when remaining count reaches 0 and result loads.
REQ-014 in_ready SHALL be 1 only in IDLE and when (!out_valid || out_ready).
REQ-015 add/sub/or/and/slt SHALL load result one cycle after acceptance (latency 1); back-to-back acceptance every cycle SHALL be sustained while out_ready = 1.
REQ-016 add/sub SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-017 slt SHALL compare src_a < src_b signed; result = 1 or 0, zero-extended.
REQ-018 Shifts SHALL use shamt = src_b[4:0], operate 1 bit per cycle; latency shamt+1 cycles; shamt 0 SHALL complete with latency 1 and result = src_a.
REQ-019 sra SHALL replicate src_a[WIDTH-1]; srl/sll SHALL fill with 0.
REQ-020 result, zero, illegal SHALL remain stable while out_valid && !out_ready.
REQ-021 out_valid SHALL clear on drain unless a new result loads the same cycle.
REQ-022 Inputs SHALL be ignored in SHIFT; operands captured at acceptance only.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, shift count 0, out_valid 0, result 0, zero 1, illegal 0, in_ready 0 while asserted.
REQ-024 Reset during SHIFT SHALL abort the operation; no result produced after release.

Configuration
REQ-025 Macro ALU_EXEC_SHIFT_EN defined: shift ops per REQ-013/018/019.
REQ-026 ALU_EXEC_SHIFT_EN undefined: SHIFT state and counter absent; codes 100/110/111 SHALL complete in latency 1 with result 0, zero 1, illegal 1; other ops set illegal 0.

Structure
REQ-027 Op-code constants (ALU_ADD..ALU_SRA) and FSM state encoding SHALL live in shared package alu_pkg, also used by the ALU decoder.
REQ-028 Bit-serial shifter with counter SHALL be sub-module alu_serial_shifter, instantiated only under ALU_EXEC_SHIFT_EN.

Verification
REQ-029 add 0xFFFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid=1, result 0, zero 1.
REQ-030 slt src_a=0xFFFFFFFE, src_b=0x00000001 -> result 1; swapped -> result 0, zero 1.
REQ-031 sra src_a=0x80000000, src_b=4 -> in_ready 0 for 4 cycles, out_valid on 5th, result 0xF8000000.
REQ-032 out_ready=0 for 3 cycles after sub 5-7 -> result 0xFFFFFFFE held, in_ready 0; out_ready=1 with new and 0xF0 & 0x3C -> drain and accept same cycle, next result 0x30.
REQ-033 rst_n pulsed low mid sll (shamt 10) -> out_valid 0, in_ready 1 after release, no stale result.
REQ-034 build without ALU_EXEC_SHIFT_EN, srl 0x10 by 1 -> latency 1, result 0, illegal 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU execute unit.
//   alu_op_e      : 3-bit op codes ALU_ADD..ALU_SRA, used by the decoder
//                   in alu_execute_unit and by alu_serial_shifter.
//   exec_state_e  : execute-unit FSM state encoding (IDLE / SHIFT).
//   SHAMT_W       : shift-amount width, taken from src_b[SHAMT_W-1:0].
//   is_shift_op() : true for the three shift op codes.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_AND = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } exec_state_e;

  localparam int unsigned SHAMT_W = 5;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter -- bit-serial shifter, one bit position per clock.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load op/data/shamt (only issued with shamt != 0)
//   op          : ALU_SLL, ALU_SRL or ALU_SRA
//   data        : operand to shift
//   shamt       : number of positions to shift
//   done        : high during the cycle whose edge performs the last step
//   shift_out   : fully shifted value, valid while done is high
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [WIDTH-1:0]   shift_out
);

  alu_op_e            op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_step;
  logic [SHAMT_W-1:0] cnt_q;

  // One-position shift of the working register; sra keeps the sign bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data_step = {1'b0, data_q[WIDTH-1:1]};
    case (op_q)
      ALU_SLL: data_step = {data_q[WIDTH-2:0], 1'b0};
      ALU_SRA: data_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default: data_step = {1'b0, data_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      op_q   <= ALU_SLL;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      op_q   <= op;
      data_q <= data;
      cnt_q  <= shamt;
    end else if (cnt_q != '0) begin
      data_q <= data_step;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // The final step is taken combinationally so the result register can load
  // on the same edge that the count reaches zero.
  assign done      = (cnt_q == SHAMT_W'(1));
  assign shift_out = data_step;

endmodule

// File: rtl/alu_execute_unit.sv
// alu_execute_unit -- single-issue ALU with a registered, back-pressured
// result. add/sub/or/and/slt complete with latency 1; shifts run bit-serially
// (latency shamt+1) when built with ALU_EXEC_SHIFT_EN, otherwise shift codes
// complete with latency 1 and report illegal.
// Configuration macro: ALU_EXEC_SHIFT_EN
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operation handshake
//   alu_control           : op code (see alu_pkg::alu_op_e)
//   src_a, src_b          : operands (shift amount = src_b[4:0])
//   out_valid / out_ready : result handshake
//   result, zero, illegal : registered result, (result == 0), unsupported-op
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_op_e          op;
  logic             accept;
  logic             idle;
  logic             load;
  logic [WIDTH-1:0] load_result;
  logic             load_illegal;
  logic [WIDTH-1:0] dec_result;
  logic             dec_illegal;

  assign op     = alu_op_e'(alu_control);
  assign accept = in_valid && in_ready;

  // Single-cycle decoder. With shifts enabled, a shift op only reaches the
  // result register through this path when shamt is 0, i.e. result = src_a.
  always_comb begin
    dec_result  = '0;
    dec_illegal = 1'b0;
    case (op)
      ALU_ADD: dec_result = src_a + src_b;
      ALU_SUB: dec_result = src_a - src_b;
      ALU_OR:  dec_result = src_a | src_b;
      ALU_AND: dec_result = src_a & src_b;
      ALU_SLT: dec_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_EXEC_SHIFT_EN
      default: dec_result = src_a;
`else
      default: dec_illegal = 1'b1;
`endif
    endcase
  end

`ifdef ALU_EXEC_SHIFT_EN
  exec_state_e        state_q, state_d;
  logic [SHAMT_W-1:0] shamt;
  logic               start_shift;
  logic               shift_done;
  logic [WIDTH-1:0]   shift_out;

  assign shamt       = src_b[SHAMT_W-1:0];
  assign start_shift = accept && is_shift_op(op) && (shamt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_shift) state_d = ST_SHIFT;
      ST_SHIFT: if (shift_done)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  alu_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_shift),
    .op        (op),
    .data      (src_a),
    .shamt     (shamt),
    .done      (shift_done),
    .shift_out (shift_out)
  );

  assign idle         = (state_q == ST_IDLE);
  assign load         = (accept && !start_shift) || shift_done;
  assign load_result  = shift_done ? shift_out : dec_result;
  assign load_illegal = shift_done ? 1'b0 : dec_illegal;
`else
  assign idle         = 1'b1;
  assign load         = accept;
  assign load_result  = dec_result;
  assign load_illegal = dec_illegal;
`endif

  // rst_n is folded in so in_ready reads 0 for the whole reset period.
  assign in_ready = rst_n && idle && (!out_valid || out_ready);

  // Result register: loads on completion, otherwise holds; out_valid clears
  // on drain unless a new result lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_result;
      zero      <= (load_result == '0);
      illegal   <= load_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit -- directed self-checking bench for alu_execute_unit.
// Inputs change on the falling edge; outputs are compared on the following
// falling edge, half a period after the rising edge that updated them.
// Covers the default build; the shift sequences run when ALU_EXEC_SHIFT_EN
// is defined for both bench and RTL.
module tb_alu_execute_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_execute_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                       input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ordy);
    in_valid    = v;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    out_ready   = ordy;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [WIDTH-1:0] r, input logic z,
                           input logic ill);
    check({tag, "_valid"},   WIDTH'(out_valid), WIDTH'(v));
    check({tag, "_result"},  result, r);
    check({tag, "_zero"},    WIDTH'(zero), WIDTH'(z));
    check({tag, "_illegal"}, WIDTH'(illegal), WIDTH'(ill));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 1'b1);
    tick();
    // Reset state.
    check("rst_in_ready", WIDTH'(in_ready), '0);
    check_out("rst", 1'b0, 32'h0, 1'b1, 1'b0);

    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", WIDTH'(in_ready), 32'd1);

    // Wrapping add, then back-to-back slt pair.
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    tick();
    check_out("add_wrap", 1'b1, 32'h0, 1'b1, 1'b0);
    check("b2b_in_ready", WIDTH'(in_ready), 32'd1);
    drive(1'b1, 3'b101, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    tick();
    check_out("slt_neg", 1'b1, 32'h1, 1'b0, 1'b0);
    drive(1'b1, 3'b101, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    tick();
    check_out("slt_pos", 1'b1, 32'h0, 1'b1, 1'b0);

    // Back-pressure: sub result held while out_ready low.
    drive(1'b1, 3'b001, 32'd5, 32'd7, 1'b1);
    tick();
    check_out("sub", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 32'h0000_00F0, 32'h0000_003C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", WIDTH'(in_ready), '0);
      tick();
      check_out("stall_hold", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", WIDTH'(in_ready), 32'd1);
    tick();
    check_out("and_after_drain", 1'b1, 32'h0000_0030, 1'b0, 1'b0);

    // Drain with nothing new: out_valid clears, result held.
    drive(1'b0, 3'b010, 32'h0F, 32'hF0, 1'b1);
    tick();
    check_out("drain_empty", 1'b0, 32'h0000_0030, 1'b0, 1'b0);

    drive(1'b1, 3'b010, 32'h0000_000F, 32'h0000_00F0, 1'b1);
    tick();
    check_out("or", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h0, 32'h1, 1'b1);
    tick();
    check_out("sub_wrap", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

`ifdef ALU_EXEC_SHIFT_EN
    // sra by 4: four busy cycles, result on the fifth.
    drive(1'b1, 3'b111, 32'h8000_0000, 32'd4, 1'b1);
    tick();
    drive(1'b1, 3'b000, 32'd1, 32'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("sra_busy_in_ready", WIDTH'(in_ready), '0);
      check("sra_busy_valid", WIDTH'(out_valid), '0);
      tick();
    end
    check_out("sra", 1'b1, 32'hF800_0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    // Zero-amount shift completes in one cycle with result = src_a.
    drive(1'b1, 3'b100, 32'h1234_5678, 32'h20, 1'b1);
    tick();
    check_out("sll_zero", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    drive(1'b1, 3'b110, 32'h8000_0001, 32'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check_out("srl_one", 1'b1, 32'h4000_0000, 1'b0, 1'b0);

    // Reset mid sll (shamt 10) aborts it.
    drive(1'b1, 3'b100, 32'h1, 32'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_rst_in_ready", WIDTH'(in_ready), '0);
    check("abort_rst_valid", WIDTH'(out_valid), '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_no_result", WIDTH'(out_valid), '0);
      check("abort_in_ready", WIDTH'(in_ready), 32'd1);
    end
`else
    // Shift codes unsupported: latency 1, result 0, illegal.
    drive(1'b1, 3'b110, 32'h0000_0010, 32'd1, 1'b1);
    tick();
    check_out("srl_illegal", 1'b1, 32'h0, 1'b1, 1'b1);
    check("srl_in_ready", WIDTH'(in_ready), 32'd1);
    drive(1'b1, 3'b000, 32'd2, 32'd3, 1'b1);
    tick();
    check_out("add_clears_illegal", 1'b1, 32'd5, 1'b0, 1'b0);

    // Reset while a result is stalled discards it.
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_rst_in_ready", WIDTH'(in_ready), '0);
    tick();
    rst_n = 1'b1;
    tick();
    check_out("abort_after_rst", 1'b0, 32'h0, 1'b1, 1'b0);
    check("abort_in_ready", WIDTH'(in_ready), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
